mem_request_queue: RTL and testbench
====================================

Name: mem_request_queue

Overview:
Upstream feeder for the memory access controller: accepts processor-side memory requests over a valid/ready handshake and stamps each with a transaction ID. Buffers them in a show-ahead FIFO and presents the packed word {tid, rw, address, data} on an rd_en/data_out/empty interface that the controller pops. Also tracks outstanding (issued, not yet answered) transactions and throttles acceptance against a credit limit released by returning responses.

Parameters:
DATA_WIDTH, 32, data field width
ADDR_WIDTH, 31, address field width
TID_WIDTH, 16, transaction ID width; the ID counter wraps modulo 2^TID_WIDTH
DEPTH, 8, FIFO entries (power of two)
PTR_WIDTH, 3, log2(DEPTH)
MAX_OUTSTANDING, 16, credit limit on unanswered transactions
CNT_WIDTH, 5, width of the outstanding counter; must hold MAX_OUTSTANDING
DP_DATA_WIDTH, TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH, packed output word width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  queue can accept this cycle
req_rw  in  1  access flag, carried unchanged into the packed word
req_address  in  ADDR_WIDTH  request address
req_data  in  DATA_WIDTH  request write data
req_tid  out  TID_WIDTH  ID that an accept in this cycle will receive
rd_en  in  1  consumer pop strobe
data_out  out  DP_DATA_WIDTH  head entry {tid, rw, address, data}, MSB first
empty_signal  out  1  FIFO empty
rsp_valid  in  1  one transaction completed; releases one credit
count  out  PTR_WIDTH+1  FIFO occupancy, 0..DEPTH
outstanding  out  CNT_WIDTH  issued but unanswered transactions
credit_err  out  1  sticky error flag: response received with outstanding==0

Behaviour:
- Reset (reset==0, asynchronous):
  - count=0, empty_signal=1, data_out=0.
  - Read/write pointers=0, tid counter=0, outstanding=0, credit_err=0.
  - Storage contents need not be cleared.
  - Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
- Handshake and ready:
  - req_ready = (count < DEPTH) && (outstanding < MAX_OUTSTANDING). Combinational from registered state only; no dependence on req_valid or rd_en.
  - accept = req_valid && req_ready.
- Accept:
  - Write {tid_ctr, req_rw, req_address, req_data} at the write pointer.
  - Increment the write pointer (wraps at DEPTH), increment tid_ctr (wraps to 0 after all-ones), increment outstanding.
- Pop:
  - pop = rd_en && !empty_signal. Advance the read pointer (wraps).
  - rd_en while empty is ignored: no pointer or count change, no error.
- Show-ahead output:
  - data_out = storage[rd_ptr] whenever count>0, else 0.
  - An accepted entry becomes visible on the edge after accept: empty_signal falls one cycle after the accepting edge.
- Occupancy:
  - count changes by +1 on accept only, -1 on pop only, and is unchanged when both occur.
  - Full with rd_en: the pop occurs but no push that cycle, because ready was already 0. No bypass.
  - Empty with push and rd_en in the same cycle: the push succeeds and the pop is ignored.
- Credits:
  - outstanding changes by +1 on accept and -1 on rsp_valid, and is unchanged when both occur.
  - rsp_valid with outstanding==0 and no accept that cycle: counter holds at 0 and credit_err sets, staying set until reset.
  - rsp_valid with outstanding==0 in the same cycle as an accept: counter stays 0 and no error.
- req_tid = tid_ctr combinationally; it is valid for reporting the ID at the handshake.
- All arithmetic is unsigned and pointer/ID wrap is modulo power of two; no saturation except the outstanding floor at 0.

Test Plan:
- Reset: drive reset=0 at arbitrary time -> immediately empty_signal=1, count=0, outstanding=0, req_ready=1, req_tid=0, data_out=0, credit_err=0.
- Single request: rw=1, address=31'h10, data=32'h7 accepted at edge N -> at N+1 empty_signal=0, data_out={16'h0000,1'b1,31'h10,32'h7}, outstanding=1. rd_en one cycle -> empty_signal=1, count=0.
- Fill: 8 accepts, no pops, no responses -> count=8, req_ready=0, and data_out shows ids 0..7 in order as popped. Pop plus req_valid while full -> count=7 and the request is not taken that cycle.
- Credit throttle: pop continuously with no rsp_valid -> after 16 accepts req_ready=0 while count=0. One rsp_valid -> outstanding=15, req_ready=1. rsp_valid plus accept in the same cycle -> outstanding unchanged.
- Error: rsp_valid with outstanding=0 and no accept -> credit_err=1, outstanding=0, and it stays set until reset.
- Wrap: TID_WIDTH=4, 20 accept/pop pairs -> ids run 0..15 then 0..3. Pointers wrap with no data loss.

Source files
------------

// File: rtl/mem_request_queue_if.sv
// Request-side and pop-side signals of the memory request queue.
// master = processor/controller side, slave = the queue itself.
interface mem_request_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 31,
   parameter int TID_WIDTH  = 16
);
   localparam int DP_DATA_WIDTH = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_rw;
   logic [ADDR_WIDTH-1:0]    req_address;
   logic [DATA_WIDTH-1:0]    req_data;
   logic [TID_WIDTH-1:0]     req_tid;
   logic                     rd_en;
   logic [DP_DATA_WIDTH-1:0] data_out;
   logic                     empty_signal;
   logic                     rsp_valid;

   modport master (
      output req_valid, req_rw, req_address, req_data, rd_en, rsp_valid,
      input  req_ready, req_tid, data_out, empty_signal
   );

   modport slave (
      input  req_valid, req_rw, req_address, req_data, rd_en, rsp_valid,
      output req_ready, req_tid, data_out, empty_signal
   );
endinterface

// File: rtl/mem_request_queue.sv
// Stamps accepted memory requests with a transaction ID, buffers them in a
// show-ahead FIFO and throttles acceptance against an outstanding-credit limit.
module mem_request_queue #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 31,
   parameter int TID_WIDTH       = 16,
   parameter int DEPTH           = 8,
   parameter int PTR_WIDTH       = 3,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_WIDTH       = 5,
   parameter int DP_DATA_WIDTH   = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_request_queue_if.slave   bus,
   output logic [PTR_WIDTH:0]   count,
   output logic [CNT_WIDTH-1:0] outstanding,
   output logic                 credit_err
);
   localparam logic [PTR_WIDTH:0]   FULL_COUNT   = (PTR_WIDTH + 1)'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CREDIT_LIMIT = CNT_WIDTH'(MAX_OUTSTANDING);

   logic [DP_DATA_WIDTH-1:0] storage [DEPTH];
   logic [PTR_WIDTH-1:0]     wr_ptr_reg;
   logic [PTR_WIDTH-1:0]     rd_ptr_reg;
   logic [TID_WIDTH-1:0]     tid_ctr_reg;
   logic                     accept;
   logic                     pop;

   // Ready looks only at registered state so upstream never sees a loop through rd_en.
   assign bus.req_ready    = (count < FULL_COUNT) && (outstanding < CREDIT_LIMIT);
   assign accept           = bus.req_valid && bus.req_ready;
   assign pop              = bus.rd_en && !bus.empty_signal;
   assign bus.empty_signal = (count == '0);
   assign bus.req_tid      = tid_ctr_reg;
   assign bus.data_out     = bus.empty_signal ? '0 : storage[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (accept) begin
         storage[wr_ptr_reg] <= {tid_ctr_reg, bus.req_rw, bus.req_address, bus.req_data};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         tid_ctr_reg <= '0;
         count       <= '0;
         outstanding <= '0;
         credit_err  <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr_reg  <= wr_ptr_reg + 1'b1;
            tid_ctr_reg <= tid_ctr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // A response with nothing outstanding is a protocol error; the counter floors at 0.
         case ({accept, bus.rsp_valid})
            2'b10: outstanding <= outstanding + 1'b1;
            2'b01: begin
               if (outstanding == '0) begin
                  credit_err <= 1'b1;
               end else begin
                  outstanding <= outstanding - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_request_queue.sv
// Scoreboard bench: stimulus pushes expected head words, negedge monitors compare on each pop.
// A second instance with TID_WIDTH=4 exercises ID and pointer wrap.
module tb_mem_request_queue;
   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [3:0] count_a;
   logic [4:0] outstanding_a;
   logic       credit_err_a;
   logic [3:0] count_b;
   logic [4:0] outstanding_b;
   logic       credit_err_b;

   logic [79:0] exp_q [$];
   logic [67:0] exp_b [$];
   logic [15:0] tid_a;
   logic [3:0]  tid_b;

   mem_request_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(31), .TID_WIDTH(16)) ifa ();
   mem_request_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(31), .TID_WIDTH(4))  ifb ();

   mem_request_queue #(.TID_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa.slave),
      .count(count_a), .outstanding(outstanding_a), .credit_err(credit_err_a)
   );

   mem_request_queue #(.TID_WIDTH(4)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb.slave),
      .count(count_b), .outstanding(outstanding_b), .credit_err(credit_err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitors: a pop happens on the next rising edge, so the head word is checked here.
   always @(negedge clk) begin
      if (reset && ifa.rd_en && !ifa.empty_signal) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_a_unexpected: got %h, expected no pop", ifa.data_out);
         end else begin
            $display("pop a: %h", ifa.data_out);
            check("pop_a", 96'(ifa.data_out), 96'(exp_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (reset && ifb.rd_en && !ifb.empty_signal) begin
         if (exp_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_b_unexpected: got %h, expected no pop", ifb.data_out);
         end else begin
            $display("pop b: %h", ifb.data_out);
            check("pop_b", 96'(ifb.data_out), 96'(exp_b.pop_front()));
         end
      end
   end

   // One cycle on instance A; called at posedge+1, returns at the next posedge+1.
   task automatic step_a(input logic v, input logic rw, input logic [30:0] a,
                         input logic [31:0] d, input logic rd, input logic rsp,
                         input logic exp_acc);
      ifa.req_valid   = v;
      ifa.req_rw      = rw;
      ifa.req_address = a;
      ifa.req_data    = d;
      ifa.rd_en       = rd;
      ifa.rsp_valid   = rsp;
      if (v) check("ready_a", 96'(ifa.req_ready), 96'(exp_acc));
      if (v && exp_acc) begin
         check("req_tid_a", 96'(ifa.req_tid), 96'(tid_a));
         exp_q.push_back({tid_a, rw, a, d});
      end
      @(posedge clk);
      #1;
      if (v && exp_acc) tid_a = tid_a + 1'b1;
      ifa.req_valid = 1'b0;
      ifa.rd_en     = 1'b0;
      ifa.rsp_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      tid_a = '0;
      tid_b = '0;
      ifa.req_valid = 0; ifa.req_rw = 0; ifa.req_address = '0; ifa.req_data = '0;
      ifa.rd_en = 0; ifa.rsp_valid = 0;
      ifb.req_valid = 0; ifb.req_rw = 0; ifb.req_address = '0; ifb.req_data = '0;
      ifb.rd_en = 0; ifb.rsp_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", 96'(ifa.empty_signal), 96'(1));
      check("rst_count", 96'(count_a), 96'(0));
      check("rst_ready", 96'(ifa.req_ready), 96'(1));
      check("rst_data_out", 96'(ifa.data_out), 96'(0));
      reset = 1'b1;

      // Single request, then pop, then its response.
      step_a(1, 1'b1, 31'h10, 32'h7, 0, 0, 1);
      check("single_empty", 96'(ifa.empty_signal), 96'(0));
      check("single_data", 96'(ifa.data_out), {16'h0, 16'h0000, 1'b1, 31'h10, 32'h7});
      check("single_out", 96'(outstanding_a), 96'(1));
      step_a(0, 0, '0, '0, 1, 0, 0);
      check("single_pop_empty", 96'(ifa.empty_signal), 96'(1));
      check("single_pop_count", 96'(count_a), 96'(0));
      step_a(0, 0, '0, '0, 0, 1, 0);
      check("single_rsp_out", 96'(outstanding_a), 96'(0));

      // Fill to DEPTH, then pop with a blocked request while full.
      for (int i = 0; i < 8; i++)
         step_a(1, 1'(i), 31'h100 + 31'(i), 32'hA000_0000 + 32'(i), 0, 0, 1);
      check("fill_count", 96'(count_a), 96'(8));
      check("fill_ready", 96'(ifa.req_ready), 96'(0));
      step_a(1, 1'b0, 31'h7FF, 32'hDEAD, 1, 0, 0);
      check("full_pop_count", 96'(count_a), 96'(7));
      for (int i = 0; i < 7; i++) step_a(0, 0, '0, '0, 1, 0, 0);
      check("drain_count", 96'(count_a), 96'(0));
      check("drain_out", 96'(outstanding_a), 96'(8));

      // Credit throttle: 8 more accepts while popping reaches the limit of 16.
      for (int i = 0; i < 8; i++)
         step_a(1, 1'b1, 31'h200 + 31'(i), 32'h5555_0000 + 32'(i), 1, 0, 1);
      step_a(1, 1'b0, 31'h2FF, 32'hBEEF, 1, 0, 0);
      check("throttle_count", 96'(count_a), 96'(0));
      check("throttle_out", 96'(outstanding_a), 96'(16));
      check("throttle_ready", 96'(ifa.req_ready), 96'(0));
      step_a(0, 0, '0, '0, 0, 1, 0);
      check("credit_rel_out", 96'(outstanding_a), 96'(15));
      check("credit_rel_ready", 96'(ifa.req_ready), 96'(1));
      step_a(1, 1'b1, 31'h300, 32'h1234_5678, 0, 1, 1);
      check("acc_rsp_out", 96'(outstanding_a), 96'(15));
      step_a(0, 0, '0, '0, 1, 0, 0);
      for (int i = 0; i < 15; i++) step_a(0, 0, '0, '0, 0, 1, 0);
      check("credits_zero", 96'(outstanding_a), 96'(0));
      check("no_err_yet", 96'(credit_err_a), 96'(0));

      // Response at zero together with an accept is not an error.
      step_a(1, 1'b0, 31'h400, 32'hCAFE_F00D, 0, 1, 1);
      check("zero_acc_rsp_out", 96'(outstanding_a), 96'(0));
      check("zero_acc_rsp_err", 96'(credit_err_a), 96'(0));
      step_a(0, 0, '0, '0, 1, 0, 0);
      step_a(0, 0, '0, '0, 1, 0, 0);
      check("rd_empty_count", 96'(count_a), 96'(0));
      step_a(0, 0, '0, '0, 0, 1, 0);
      check("err_set", 96'(credit_err_a), 96'(1));
      check("err_out", 96'(outstanding_a), 96'(0));
      step_a(0, 0, '0, '0, 0, 0, 0);
      step_a(0, 0, '0, '0, 0, 0, 0);
      check("err_sticky", 96'(credit_err_a), 96'(1));

      // Asynchronous reset in the middle of a cycle discards queued entries.
      for (int i = 0; i < 3; i++)
         step_a(1, 1'b1, 31'h500 + 31'(i), 32'h0F0F_0000 + 32'(i), 0, 0, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_count", 96'(count_a), 96'(0));
      check("mid_rst_empty", 96'(ifa.empty_signal), 96'(1));
      check("mid_rst_data", 96'(ifa.data_out), 96'(0));
      check("mid_rst_out", 96'(outstanding_a), 96'(0));
      check("mid_rst_tid", 96'(ifa.req_tid), 96'(0));
      check("mid_rst_err", 96'(credit_err_a), 96'(0));
      exp_q.delete();
      tid_a = '0;
      @(posedge clk);
      #1 reset = 1'b1;
      step_a(1, 1'b0, 31'h600, 32'h6666_6666, 0, 0, 1);
      step_a(0, 0, '0, '0, 1, 1, 0);
      check("post_rst_out", 96'(outstanding_a), 96'(0));

      // Wrap: 4-bit IDs over 20 accept/pop pairs, responses keep credits flat.
      for (int k = 0; k < 21; k++) begin
         ifb.req_valid   = (k < 20);
         ifb.req_rw      = 1'(k);
         ifb.req_address = 31'h700 + 31'(k);
         ifb.req_data    = 32'h9000_0000 + 32'(k);
         ifb.rd_en       = (k != 0);
         ifb.rsp_valid   = (k != 0);
         if (k < 20) begin
            check("ready_b", 96'(ifb.req_ready), 96'(1));
            check("req_tid_b", 96'(ifb.req_tid), 96'(tid_b));
            exp_b.push_back({tid_b, ifb.req_rw, ifb.req_address, ifb.req_data});
         end
         @(posedge clk);
         #1;
         if (k < 20) tid_b = tid_b + 1'b1;
      end
      ifb.req_valid = 0; ifb.rd_en = 0; ifb.rsp_valid = 0;
      check("wrap_count", 96'(count_b), 96'(0));
      check("wrap_out", 96'(outstanding_b), 96'(0));
      check("wrap_err", 96'(credit_err_b), 96'(0));
      check("wrap_tid_next", 96'(ifb.req_tid), 96'(4));

      repeat (2) @(posedge clk);
      check("sb_a_drained", 96'(exp_q.size()), 96'(0));
      check("sb_b_drained", 96'(exp_b.size()), 96'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
